// File: rtl/crop_max_buffer.sv
// Captures one AXI-Stream frame, keeps an OUT_ROWS x OUT_COLS crop and its max pixel,
// then emits the max as norm_denominator and streams the crop. Option: CROP_MAX_TLAST_EN.
module crop_max_buffer #(
  parameter int IN_ROWS  = 32,
  parameter int IN_COLS  = 32,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10,
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1,
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ap_start,
  output logic          ap_ready,
  output logic          ap_done,
  input  logic [RW-1:0] row_start,
  input  logic [CW-1:0] col_start,
  output logic          crop_clamped,
  output logic          frame_err,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [7:0]    s_axis_tdata,
  input  logic          s_axis_tuser,
  output logic [7:0]    norm_denominator,
  output logic          norm_denominator_tvalid,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [7:0]    m_axis_tdata,
  output logic          m_axis_tlast
);
  localparam int DEPTH = OUT_ROWS * OUT_COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW    = AW + 1;
  localparam logic [RW-1:0] MAX_R = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] MAX_C = CW'(IN_COLS - OUT_COLS);

  typedef enum logic [2:0] {IDLE, SYNC, CAPTURE, EMIT, STREAM} state_t;
  state_t state;

  logic [RW-1:0] org_r, in_row, pix_row;
  logic [CW-1:0] org_c, in_col, pix_col;
  logic [AW-1:0] wr_addr, pix_addr;
  logic [7:0]    max_px, max_base;
  logic [7:0]    mem [DEPTH];
  logic [NW-1:0] rd_addr, out_cnt;
  logic [7:0]    ram_q;
  logic          ram_v;
  logic          accept, take, in_win, last_px, out_free, issue, hs, final_hs;

  assign ap_ready      = (state == IDLE);
  assign s_axis_tready = (state == SYNC) || (state == CAPTURE);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign take          = accept && ((state == CAPTURE) || s_axis_tuser);

  // A tuser beat always counts as pixel (0,0), whether first or a resync.
  assign pix_row  = s_axis_tuser ? '0 : in_row;
  assign pix_col  = s_axis_tuser ? '0 : in_col;
  assign pix_addr = s_axis_tuser ? '0 : wr_addr;
  assign max_base = s_axis_tuser ? 8'd0 : max_px;
  assign in_win   = (pix_row >= org_r) && ({1'b0, pix_row} < ({1'b0, org_r} + (RW+1)'(OUT_ROWS))) &&
                    (pix_col >= org_c) && ({1'b0, pix_col} < ({1'b0, org_c} + (CW+1)'(OUT_COLS)));
  assign last_px  = (pix_row == RW'(IN_ROWS - 1)) && (pix_col == CW'(IN_COLS - 1));

  // ram_q is only overwritten once its pixel moves into the output register.
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign issue    = (state == STREAM) && (rd_addr < NW'(DEPTH)) && (!ram_v || out_free);
  assign hs       = m_axis_tvalid && m_axis_tready;
  assign final_hs = hs && (out_cnt == NW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (take && in_win) mem[pix_addr] <= s_axis_tdata;
    if (issue) ram_q <= mem[rd_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      org_r                   <= '0;
      org_c                   <= '0;
      in_row                  <= '0;
      in_col                  <= '0;
      wr_addr                 <= '0;
      max_px                  <= '0;
      rd_addr                 <= '0;
      out_cnt                 <= '0;
      ram_v                   <= 1'b0;
      ap_done                 <= 1'b0;
      crop_clamped            <= 1'b0;
      frame_err               <= 1'b0;
      norm_denominator        <= '0;
      norm_denominator_tvalid <= 1'b0;
      m_axis_tvalid           <= 1'b0;
      m_axis_tdata            <= '0;
    end else begin
      ap_done <= 1'b0;
      case (state)
        IDLE: if (ap_start) begin
          org_r        <= (row_start > MAX_R) ? MAX_R : row_start;
          org_c        <= (col_start > MAX_C) ? MAX_C : col_start;
          crop_clamped <= (row_start > MAX_R) || (col_start > MAX_C);
          frame_err    <= 1'b0;
          in_row       <= '0;
          in_col       <= '0;
          wr_addr      <= '0;
          max_px       <= '0;
          state        <= SYNC;
        end
        SYNC, CAPTURE: if (take) begin
          if (state == CAPTURE && s_axis_tuser) frame_err <= 1'b1;
          wr_addr <= in_win ? pix_addr + AW'(1) : pix_addr;
          max_px  <= (in_win && s_axis_tdata > max_base) ? s_axis_tdata : max_base;
          if (last_px) begin
            state <= EMIT;
          end else begin
            state <= CAPTURE;
            if (pix_col == CW'(IN_COLS - 1)) begin
              in_col <= '0;
              in_row <= pix_row + RW'(1);
            end else begin
              in_col <= pix_col + CW'(1);
              in_row <= pix_row;
            end
          end
        end
        EMIT: begin
          norm_denominator        <= (max_px == 8'd0) ? 8'd1 : max_px;
          norm_denominator_tvalid <= 1'b1;
          rd_addr                 <= '0;
          out_cnt                 <= '0;
          ram_v                   <= 1'b0;
          state                   <= STREAM;
        end
        STREAM: begin
          if (issue) rd_addr <= rd_addr + NW'(1);
          ram_v <= issue || (ram_v && !out_free);
          if (out_free) begin
            m_axis_tvalid <= ram_v;
            m_axis_tdata  <= ram_q;
          end
          if (hs) out_cnt <= out_cnt + NW'(1);
          if (final_hs) begin
            ap_done                 <= 1'b1;
            m_axis_tvalid           <= 1'b0;
            norm_denominator_tvalid <= 1'b0;
            state                   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CROP_MAX_TLAST_EN
  localparam int OCW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  logic [OCW-1:0] out_col;
  always_ff @(posedge clk) begin
    if (reset || state == EMIT) out_col <= '0;
    else if (hs) out_col <= (out_col == OCW'(OUT_COLS - 1)) ? '0 : out_col + OCW'(1);
  end
  assign m_axis_tlast = m_axis_tvalid && (out_col == OCW'(OUT_COLS - 1));
`else
  assign m_axis_tlast = 1'b0;
`endif
endmodule
